// File: rtl/fifo_read_ctrl.sv
// Drain-side controller for fifo_sync: pops the FIFO into a 2-entry output buffer and
// presents it as a valid/ready stream with packet-last tagging. Optional stats: FIFO_RD_STATS_EN.
module fifo_read_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int PKT_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drain_en,
  input  logic                 fifo_empty,
  input  logic [BIT_WIDTH-1:0] fifo_read_data,
  output logic                 fifo_read_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [31:0]          stat_words,
  output logic [31:0]          stat_stalls
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [1:0]           cnt_reg, cnt_next;
  logic [BIT_WIDTH-1:0] data_reg [2];
  logic [BIT_WIDTH-1:0] data_next [2];
  logic                 last_reg [2];
  logic                 last_next [2];
  logic [15:0]          push_idx_reg, push_idx_next;
  logic [15:0]          pkt_idx_reg, pkt_idx_next;
  logic                 push, pop;

  // Read issue never depends on out_ready, so the FIFO pop path stays short.
  assign fifo_read_en = drain_en & ~fifo_empty & (cnt_reg != 2'd2) & ~rst;
  assign push         = fifo_read_en;
  assign out_valid    = (cnt_reg != 2'd0);
  assign pop          = out_valid & out_ready;
  assign out_data     = data_reg[0];
  assign out_last     = last_reg[0];

  always_comb begin
    cnt_next      = cnt_reg + 2'(push) - 2'(pop);
    data_next     = data_reg;
    last_next     = last_reg;
    push_idx_next = push_idx_reg;
    pkt_idx_next  = pkt_idx_reg;

    if (pop) begin
      data_next[0] = data_reg[1];
      last_next[0] = last_reg[1];
    end

    // The tail is slot 0 when the buffer is (or is becoming) empty, else slot 1.
    if (push) begin
      if ((cnt_reg == 2'd0) || ((cnt_reg == 2'd1) && pop)) begin
        data_next[0] = fifo_read_data;
        last_next[0] = (push_idx_reg == LAST_IDX);
      end else begin
        data_next[1] = fifo_read_data;
        last_next[1] = (push_idx_reg == LAST_IDX);
      end
      push_idx_next = (push_idx_reg == LAST_IDX) ? 16'd0 : push_idx_reg + 16'd1;
    end

    if (pop) begin
      pkt_idx_next = (pkt_idx_reg == LAST_IDX) ? 16'd0 : pkt_idx_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= 2'd0;
      data_reg[0]  <= '0;
      data_reg[1]  <= '0;
      last_reg[0]  <= 1'b0;
      last_reg[1]  <= 1'b0;
      push_idx_reg <= 16'd0;
      pkt_idx_reg  <= 16'd0;
    end else begin
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      last_reg     <= last_next;
      push_idx_reg <= push_idx_next;
      pkt_idx_reg  <= pkt_idx_next;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] stat_words_reg, stat_stalls_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_reg  <= 32'd0;
      stat_stalls_reg <= 32'd0;
    end else begin
      if (pop) stat_words_reg <= stat_words_reg + 32'd1;
      if (out_valid && !out_ready) stat_stalls_reg <= stat_stalls_reg + 32'd1;
    end
  end

  assign stat_words  = stat_words_reg;
  assign stat_stalls = stat_stalls_reg;
`else
  assign stat_words  = 32'd0;
  assign stat_stalls = 32'd0;
`endif

endmodule
